// File: rtl/seg7_pkg.sv
// Glyph codes, active-low segment patterns and the power-up message for the marquee scroller.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a cleared bit lights the segment.
package seg7_pkg;

  typedef enum logic [3:0] {
    GlyphBlank = 4'd0,
    GlyphD     = 4'd1,
    GlyphE     = 4'd2,
    GlyphO     = 4'd3,
    GlyphH     = 4'd4,
    GlyphL     = 4'd5,
    GlyphP     = 4'd6,
    Glyph0     = 4'd7,
    Glyph1     = 4'd8,
    Glyph2     = 4'd9,
    Glyph3     = 4'd10,
    Glyph4     = 4'd11,
    Glyph5     = 4'd12,
    Glyph6     = 4'd13,
    Glyph7     = 4'd14
  } glyph_t;

  localparam logic [6:0] SegBlank = 7'h7F;

  // Takes the raw 4-bit code so that codes outside glyph_t fall through to blank.
  function automatic logic [6:0] glyph_to_seg(logic [3:0] code);
    case (code)
      GlyphD:  return 7'h21;
      GlyphE:  return 7'h06;
      GlyphO:  return 7'h40;
      GlyphH:  return 7'h09;
      GlyphL:  return 7'h47;
      GlyphP:  return 7'h0C;
      Glyph0:  return 7'h40;
      Glyph1:  return 7'h79;
      Glyph2:  return 7'h24;
      Glyph3:  return 7'h30;
      Glyph4:  return 7'h19;
      Glyph5:  return 7'h12;
      Glyph6:  return 7'h02;
      Glyph7:  return 7'h78;
      default: return SegBlank;
    endcase
  endfunction

  // DEFAULT_MSG: "dEO" followed by blanks for any buffer depth.
  function automatic glyph_t default_msg(int unsigned idx);
    case (idx)
      0:       return GlyphD;
      1:       return GlyphE;
      2:       return GlyphO;
      default: return GlyphBlank;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph-code to active-low 7-segment decoder, one instance per digit.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] glyph_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = glyph_to_seg(glyph_i);

endmodule

// File: rtl/seg7_marquee_scroller.sv
// Scrolls a writable glyph buffer across NUM_DIGITS active-low 7-segment displays.
// Define MARQUEE_BLINK_EN to blink the display while paused.
module seg7_marquee_scroller
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_HZ    = 1,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  localparam int unsigned AW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic                    en,
  input  logic                    dir,
  input  logic [1:0]              speed,
  input  logic                    step,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [3:0]              wr_glyph,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [AW-1:0]           pos,
  output logic                    tick_o
);

  localparam int unsigned BaseDiv = (CLK_HZ / STEP_HZ > 0) ? CLK_HZ / STEP_HZ : 1;
  localparam int unsigned CW      = (BaseDiv > 1) ? $clog2(BaseDiv) : 1;
  localparam logic [CW:0]   OneW    = (CW+1)'(1);
  localparam logic [AW-1:0] LastPos = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   LenW    = (AW+1)'(MSG_LEN);

  typedef enum logic [0:0] {StPause, StRun} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           presc_q, presc_d;
  logic [CW:0]             div, last_cnt;
  logic                    step_q;
  logic [AW-1:0]           pos_q, pos_d;
  logic                    advance;
  logic                    tick_q;
  logic [3:0]              msg_q [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] seg_all, hex_d, hex_q;

  always_comb begin
    div = (CW+1)'(BaseDiv) >> speed;
    if (div == '0) div = OneW;
    last_cnt = div - OneW;
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state_q <= StPause;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPause: if (en)  state_d = StRun;
      StRun:   if (!en) state_d = StPause;
    endcase
  end

  // FSM outputs: prescaler update and position advance
  always_comb begin
    presc_d = presc_q;
    advance = 1'b0;
    if (state_q == StRun) begin
      // >= so a speed change that shrinks DIV below the count wraps instead of overrunning
      if ({1'b0, presc_q} >= last_cnt) begin
        presc_d = '0;
        advance = 1'b1;
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end else begin
      advance = step & ~step_q;
    end

    pos_d = pos_q;
    if (advance) begin
      if (dir) pos_d = (pos_q == '0) ? LastPos : pos_q - AW'(1);
      else     pos_d = (pos_q == LastPos) ? '0 : pos_q + AW'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [AW:0]   sum;
    logic [AW-1:0] idx;
    assign sum = {1'b0, pos_q} + (AW+1)'(i);
    assign idx = (sum >= LenW) ? AW'(sum - LenW) : AW'(sum);
    seg7_glyph_decoder u_dec (
      .glyph_i(msg_q[idx]),
      .seg_o  (seg_all[7*(NUM_DIGITS-1-i) +: 7])
    );
  end

`ifdef MARQUEE_BLINK_EN
  logic [CW-1:0] blink_cnt_q;
  logic          blink_off_q;
  logic [CW:0]   half;

  always_comb begin
    half = div >> 1;
    if (half == '0) half = OneW;
  end

  // Held clear while running so every PAUSE entry starts with glyphs visible.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (state_q == StRun) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if ({1'b0, blink_cnt_q} >= half - OneW) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

  assign hex_d = blink_off_q ? '1 : seg_all;
`else
  assign hex_d = seg_all;
`endif

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      presc_q <= '0;
      step_q  <= 1'b0;
      pos_q   <= '0;
      tick_q  <= 1'b0;
      hex_q   <= '1;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= default_msg(i);
    end else begin
      presc_q <= presc_d;
      step_q  <= step;
      pos_q   <= pos_d;
      tick_q  <= advance;
      hex_q   <= hex_d;
      if (wr_en && ({1'b0, wr_addr} < LenW)) msg_q[wr_addr] <= wr_glyph;
    end
  end

  assign hex_out = hex_q;
  assign pos     = pos_q;
  assign tick_o  = tick_q;

endmodule

// File: tb/tb_seg7_marquee_scroller.sv
// Self-checking bench for seg7_marquee_scroller: directed scenarios then random stimulus
// against a cycle-level reference model of the scrolling rules.
module tb_seg7_marquee_scroller;

  // Six-entry buffer keeps a non-power-of-two wrap and leaves addresses 6,7 out of range.
  localparam int unsigned CLK_HZ = 8;
  localparam int unsigned STEP_HZ = 1;
  localparam int unsigned ND = 4;
  localparam int unsigned ML = 6;
  localparam int unsigned AW = 3;

  logic            Clk = 1'b0;
  logic            Clr, en, dir, step, wr_en;
  logic [1:0]      speed;
  logic [AW-1:0]   wr_addr;
  logic [3:0]      wr_glyph;
  logic [7*ND-1:0] hex_out;
  logic [AW-1:0]   pos;
  logic            tick_o;

  seg7_marquee_scroller #(
    .CLK_HZ    (CLK_HZ),
    .STEP_HZ   (STEP_HZ),
    .NUM_DIGITS(ND),
    .MSG_LEN   (ML)
  ) dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .en      (en),
    .dir     (dir),
    .speed   (speed),
    .step    (step),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_glyph(wr_glyph),
    .hex_out (hex_out),
    .pos     (pos),
    .tick_o  (tick_o)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  int              m_pos, m_cnt;
  int              m_msg [ML];
  bit              m_run, m_step_prev, m_tick;
  logic [7*ND-1:0] m_hex;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Active-low patterns written as the complement of the lit segments {g..a}.
  function automatic logic [6:0] seg_of(int g);
    case (g)
      1:       return ~7'h5E; // d
      2:       return ~7'h79; // E
      3:       return ~7'h3F; // O
      4:       return ~7'h76; // H
      5:       return ~7'h38; // L
      6:       return ~7'h73; // P
      7:       return ~7'h3F; // 0
      8:       return ~7'h06;
      9:       return ~7'h5B;
      10:      return ~7'h4F;
      11:      return ~7'h66;
      12:      return ~7'h6D;
      13:      return ~7'h7D;
      14:      return ~7'h07; // 7
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] show(int p);
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[7*(ND-1-i) +: 7] = seg_of(m_msg[(p + i) % ML]);
    return r;
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_cnt = 0;
    m_run = 0;
    m_step_prev = 0;
    m_tick = 0;
    m_hex = '1;
    for (int i = 0; i < ML; i++) m_msg[i] = (i < 3) ? i + 1 : 0;
  endtask

  // Applies one rising edge worth of behaviour using the inputs present at that edge.
  task automatic model_step();
    int div;
    bit adv;
    div = (CLK_HZ / STEP_HZ) >> speed;
    if (div < 1) div = 1;
    adv = 0;
    if (m_run) begin
      if (m_cnt >= div - 1) begin
        m_cnt = 0;
        adv = 1;
      end else begin
        m_cnt++;
      end
    end else begin
      adv = step && !m_step_prev;
    end
    m_step_prev = step;
    m_hex = show(m_pos);
    if (adv) m_pos = dir ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
    if (wr_en && wr_addr < ML) m_msg[wr_addr] = wr_glyph;
    m_run = en;
    m_tick = adv;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("hex", hex_out, m_hex);
    check("pos", pos, m_pos);
    check("tick", tick_o, m_tick);
  endtask

  task automatic do_clr();
    #2 Clr = 1'b1;
    #1;
    check("clr_hex", hex_out, 32'h0FFF_FFFF);
    check("clr_pos", pos, 0);
    check("clr_tick", tick_o, 0);
    model_reset();
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  initial begin
    int first, ticks;
    bit reached;
    Clr = 1'b1; en = 0; dir = 0; speed = 0; step = 0; wr_en = 0; wr_addr = 0; wr_glyph = 0;
    repeat (2) @(negedge Clk);
    check("rst_hex", hex_out, 32'h0FFF_FFFF);
    check("rst_pos", pos, 0);
    check("rst_tick", tick_o, 0);
    model_reset();
    Clr = 1'b0;
    cycle();
    check("hex_default", hex_out, {4'h0, 7'h21, 7'h06, 7'h40, 7'h7F});

    // First advance comes after 8 RUN cycles, i.e. 9 edges after en rises.
    en = 1;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (tick_o && first < 0) first = k;
    end
    check("first_tick", first, 9);
    repeat (8 * ML) cycle();

    en = 0;
    repeat (2) cycle();
    step = 1;
    ticks = 0;
    repeat (20) begin
      cycle();
      ticks += int'(tick_o);
    end
    step = 0;
    cycle();
    check("step_once", ticks, 1);

    en = 1;
    reached = 0;
    for (int k = 0; k < 30 && !reached; k++) begin
      cycle();
      if (m_run && m_cnt == 5) reached = 1;
    end
    check("presc_at_5", reached, 1);
    speed = 3;
    ticks = 0;
    repeat (4) begin
      cycle();
      ticks += int'(tick_o);
    end
    check("fast_ticks", ticks, 4);

    wr_en = 1; wr_addr = 3; wr_glyph = 4;
    cycle();
    wr_addr = 7; wr_glyph = 5;
    cycle();
    wr_en = 0;
    repeat (3) cycle();

    speed = 0;
    repeat (5) cycle();
    do_clr();
    repeat (3) cycle();

    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step = ~step;
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_glyph = 4'($urandom_range(0, 15));
      cycle();
      if ($urandom_range(0, 399) == 0) do_clr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
